shift_compare_reg: RTL and testbench
====================================

Name: shift_compare_reg

Overview:
Parametrised register that generalises the plain, compare and multiplexer register bits into one word-wide block. It supports hold, muxed parallel load, serial shift and clear. A shift counter and a registered masked pattern comparator are added. It sits beside the serial engines (1-wire ID readers, CPLD/config shifters) so they can assemble or emit words and detect signatures without separate glue logic.

Parameters:
WIDTH, 8, register width in bits (1..32)
INIT, 0, value loaded on reset and by the CLEAR op (WIDTH bits used)
MSB_FIRST, 1, 1: shift toward MSB, serialOut = bit WIDTH-1; 0: shift toward LSB, serialOut = bit 0
CNT_WIDTH, $clog2(WIDTH+1), width of the internal shift counter (localparam, not overridable)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; overrides every other input
clkEn  input  1  state update enable for register, counter, done
op  input  2  0 HOLD, 1 LOAD, 2 SHIFT, 3 CLEAR
sel  input  1  LOAD source: 0 valueA, 1 valueB
invert  input  1  LOAD: store bitwise inverse of selected source
valueA  input  WIDTH  parallel load source A
valueB  input  WIDTH  parallel load source B
serialIn  input  1  bit inserted at the vacated end during SHIFT
pattern  input  WIDTH  compare pattern
mask  input  WIDTH  compare mask, 1 = bit participates
valueOut  output  WIDTH  current register contents
serialOut  output  1  combinational from register (end per MSB_FIRST)
match  output  1  registered: ((valueOut ^ pattern) & mask) == 0
done  output  1  one-cycle pulse after the WIDTH-th consecutive shift

Behaviour:
- Reset (sync): valueOut=INIT, counter=0, done=0, match=0. Reset wins over clkEn and op in the same cycle.
- clkEn=0: valueOut and counter hold; done=0 that cycle. match still updates every clk.
- HOLD: no change; counter holds; done=0.
- LOAD: valueOut <= (sel ? valueB : valueA) ^ {WIDTH{invert}}; counter <= 0; done=0.
- SHIFT, MSB_FIRST=1: valueOut <= {valueOut[WIDTH-2:0], serialIn}. MSB_FIRST=0: valueOut <= {serialIn, valueOut[WIDTH-1:1]}. WIDTH=1: valueOut <= serialIn.
- SHIFT counter:
  - If counter == WIDTH-1: counter <= 0 and done <= 1 (visible the cycle after the WIDTH-th shift).
  - Otherwise counter increments and done <= 0.
  - WIDTH=1: done pulses after every shift.
- CLEAR: valueOut <= INIT; counter <= 0; done=0.
- match latency: one cycle after valueOut/pattern/mask change. mask=0 makes match=1 on the first cycle after reset.
- serialOut has zero latency relative to valueOut. During SHIFT it shows the bit being shifted out this cycle.
- Non-shift ops interrupt a count: LOAD/CLEAR restart it, HOLD pauses it (the counter is retained across HOLD).
- Reset mid-count: counter=0 and no done pulse is produced.
- No X propagation: all state has a defined reset value.

Decomposition:
- Shared package (spartanxl_pkg): op code constants OP_HOLD=0, OP_LOAD=1, OP_SHIFT=2, OP_CLEAR=3.
- One sub-module, shift_compare_cell: a per-bit 4:1 next-value mux (hold/load/shift-neighbour/INIT bit) plus FF with sync reset and CE. It maps onto one F/G LUT plus FFX/FFY per bit, two bits per CLB.
- The top level instantiates the cells with a generate loop and holds the counter, done and match logic.

Test Plan:
- Reset with INIT=8'hA5, WIDTH=8 -> valueOut=8'hA5, match=0, done=0; after reset release with mask=0 -> match=1 next cycle.
- LOAD sel=1 invert=1 valueB=8'h0F -> valueOut=8'hF0 next cycle; pattern=8'hF0 mask=8'hFF -> match=1 one cycle later.
- MSB_FIRST=1, LOAD 8'h00 then 8 SHIFTs with serialIn=1,0,1,1,0,0,1,0 -> valueOut=8'hB2; done high exactly one cycle after the 8th shift, low otherwise.
- MSB_FIRST=0, LOAD 8'h81, one SHIFT serialIn=0 -> serialOut=1 before the shift, valueOut=8'h40 after.
- 5 SHIFTs, 2 HOLDs, 3 SHIFTs -> done after the 8th shift. Repeat with a LOAD instead of the HOLDs -> no done until 8 more shifts.
- clkEn=0 during SHIFT -> valueOut unchanged, done=0. Reset asserted with op=LOAD -> valueOut=INIT. WIDTH=1 instance: every SHIFT produces done.

Source files
------------

// File: rtl/spartanxl_pkg.sv
//------------------------------------------------------------------------------
// Module   : spartanxl_pkg
// Brief    : Op codes shared by the shift/compare register and its bit cells.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package spartanxl_pkg;

  localparam logic [1:0] OP_HOLD  = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_SHIFT = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    OPC_HOLD  = 2'd0,
    OPC_LOAD  = 2'd1,
    OPC_SHIFT = 2'd2,
    OPC_CLEAR = 2'd3
  } op_e;

  // True for the ops that restart a shift count.
  function automatic logic is_restart(input logic [1:0] op);
    return (op == OP_LOAD) || (op == OP_CLEAR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_compare_cell.sv
//------------------------------------------------------------------------------
// Module   : shift_compare_cell
// Brief    : One register bit: 4:1 next-value mux (hold/load/shift/init) + FF.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_compare_cell
  import spartanxl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] op,
  input  logic       load_bit,
  input  logic       shift_bit,
  input  logic       init_bit,
  output logic       q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= init_bit;
    end else if (ce) begin
      case (op)
        OP_LOAD:  q <= load_bit;
        OP_SHIFT: q <= shift_bit;
        OP_CLEAR: q <= init_bit;
        default:  q <= q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_compare_reg.sv
//------------------------------------------------------------------------------
// Module   : shift_compare_reg
// Brief    : Word register with muxed load, serial shift, shift counter with
//            done pulse and a registered masked pattern comparator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_compare_reg
  import spartanxl_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] INIT      = 32'h0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clkEn,
  input  logic [1:0]       op,
  input  logic             sel,
  input  logic             invert,
  input  logic [WIDTH-1:0] valueA,
  input  logic [WIDTH-1:0] valueB,
  input  logic             serialIn,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] valueOut,
  output logic             serialOut,
  output logic             match,
  output logic             done
);

  localparam int                   CNT_WIDTH = $clog2(WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0]     INIT_VAL  = INIT[WIDTH-1:0];

  logic [WIDTH-1:0]     load_val;
  logic [WIDTH-1:0]     shift_val;
  logic [CNT_WIDTH-1:0] cnt;

  assign load_val = (sel ? valueB : valueA) ^ {WIDTH{invert}};

  // Each cell takes its shift input from the neighbour on the serialIn side.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (MSB_FIRST) begin : g_msb
      if (i == 0) begin : g_end
        assign shift_val[i] = serialIn;
      end else begin : g_mid
        assign shift_val[i] = valueOut[i-1];
      end
    end else begin : g_lsb
      if (i == WIDTH - 1) begin : g_end
        assign shift_val[i] = serialIn;
      end else begin : g_mid
        assign shift_val[i] = valueOut[i+1];
      end
    end

    shift_compare_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .ce        (clkEn),
      .op        (op),
      .load_bit  (load_val[i]),
      .shift_bit (shift_val[i]),
      .init_bit  (INIT_VAL[i]),
      .q         (valueOut[i])
    );
  end

  assign serialOut = MSB_FIRST ? valueOut[WIDTH-1] : valueOut[0];

  // Counter pauses on HOLD and clkEn=0; done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (!clkEn) begin
      done <= 1'b0;
    end else if (op == OP_SHIFT) begin
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        done <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_WIDTH'(1);
        done <= 1'b0;
      end
    end else begin
      if (is_restart(op)) begin
        cnt <= '0;
      end
      done <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      match <= 1'b0;
    end else begin
      match <= ~|((valueOut ^ pattern) & mask);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_compare_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_shift_compare_reg
// Brief    : Self-checking bench for three shift_compare_reg configurations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_compare_reg;

  logic       clk = 1'b0;
  logic       reset, clkEn, sel, invert, serialIn;
  logic [1:0] op;
  logic [7:0] valueA, valueB, pattern, mask;

  logic [7:0] vo_m, vo_l;
  logic [0:0] vo_1;
  logic       so_m, so_l, so_1, mt_m, mt_l, mt_1, dn_m, dn_l, dn_1;

  int nvec = 0;
  int nerr = 0;
  bit chk  = 0;

  // Model state per instance: 0 = W8 MSB-first, 1 = W8 LSB-first, 2 = W1.
  int unsigned wid [3] = '{8, 8, 1};
  bit          msbf[3] = '{1, 0, 1};
  int unsigned init[3] = '{8'hA5, 8'h3C, 1};
  int unsigned mval[3];
  int unsigned mcnt[3];
  bit          mdone[3], mmatch[3];

  always #5 clk = ~clk;

  shift_compare_reg #(.WIDTH(8), .INIT(32'hA5), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .clkEn(clkEn), .op(op), .sel(sel), .invert(invert),
    .valueA(valueA), .valueB(valueB), .serialIn(serialIn), .pattern(pattern),
    .mask(mask), .valueOut(vo_m), .serialOut(so_m), .match(mt_m), .done(dn_m));

  shift_compare_reg #(.WIDTH(8), .INIT(32'h3C), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .clkEn(clkEn), .op(op), .sel(sel), .invert(invert),
    .valueA(valueA), .valueB(valueB), .serialIn(serialIn), .pattern(pattern),
    .mask(mask), .valueOut(vo_l), .serialOut(so_l), .match(mt_l), .done(dn_l));

  shift_compare_reg #(.WIDTH(1), .INIT(32'h1), .MSB_FIRST(1'b1)) dut_1 (
    .clk(clk), .reset(reset), .clkEn(clkEn), .op(op), .sel(sel), .invert(invert),
    .valueA(valueA[0:0]), .valueB(valueB[0:0]), .serialIn(serialIn),
    .pattern(pattern[0:0]), .mask(mask[0:0]), .valueOut(vo_1), .serialOut(so_1),
    .match(mt_1), .done(dn_1));

  task automatic cmp(input string name, input int unsigned act, input int unsigned exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_bit(input string name, input logic act, input bit exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic [7:0] vo, input logic so,
                            input logic mt, input logic dn);
    int unsigned m;
    m = (1 << wid[k]) - 1;
    nvec++;
    if (((vo & m) !== mval[k]) || ((vo & ~m) !== 0)) begin
      nerr++;
      $display("FAIL inst%0d valueOut: got %0h expected %0h at %0t", k, vo, mval[k], $time);
    end
    cmp_bit($sformatf("inst%0d serialOut", k), so,
            msbf[k] ? mval[k][wid[k]-1] : mval[k][0]);
    cmp_bit($sformatf("inst%0d match", k), mt, mmatch[k]);
    cmp_bit($sformatf("inst%0d done", k), dn, mdone[k]);
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check_inst(0, vo_m, so_m, mt_m, dn_m);
      check_inst(1, vo_l, so_l, mt_l, dn_l);
      check_inst(2, {7'b0, vo_1}, so_1, mt_1, dn_1);
    end
  end

  // Apply one cycle of stimulus and advance the model by the stated rules.
  task automatic step(input logic [1:0] o, input logic s = 0, input logic inv = 0,
                      input logic [7:0] a = 0, input logic [7:0] b = 0,
                      input logic sin = 0, input logic en = 1, input logic rst = 0);
    int unsigned nv[3], nc[3];
    bit nd[3], nm[3];
    op = o; sel = s; invert = inv; valueA = a; valueB = b;
    serialIn = sin; clkEn = en; reset = rst;
    for (int k = 0; k < 3; k++) begin
      int unsigned full, src;
      full = 1 << wid[k];
      nv[k] = mval[k]; nc[k] = mcnt[k]; nd[k] = 0;
      nm[k] = (((mval[k] ^ pattern) & mask) % full) == 0;
      if (rst) begin
        nv[k] = init[k]; nc[k] = 0; nm[k] = 0;
      end else if (en) begin
        case (o)
          2'd1: begin
            src = s ? b : a;
            if (inv) src = ~src;
            nv[k] = src % full; nc[k] = 0;
          end
          2'd2: begin
            if (msbf[k]) nv[k] = (mval[k] * 2 + sin) % full;
            else         nv[k] = mval[k] / 2 + sin * (full / 2);
            if (mcnt[k] + 1 == wid[k]) begin nc[k] = 0; nd[k] = 1; end
            else nc[k] = mcnt[k] + 1;
          end
          2'd3: begin nv[k] = init[k]; nc[k] = 0; end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      mval[k] = nv[k]; mcnt[k] = nc[k]; mdone[k] = nd[k]; mmatch[k] = nm[k];
    end
    chk = 1;
  endtask

  initial begin
    bit bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    pattern = 8'h00; mask = 8'hFF;
    for (int k = 0; k < 3; k++) begin mval[k] = 0; mcnt[k] = 0; mdone[k] = 0; mmatch[k] = 0; end

    // Reset values, then mask=0 forces match.
    step(2'd0, .rst(1));
    cmp("reset valueOut", vo_m, 8'hA5);
    cmp("model reset value", mval[0], 8'hA5);
    cmp_bit("reset match", mt_m, 0);
    cmp_bit("reset done", dn_m, 0);
    mask = 8'h00;
    step(2'd0);
    cmp_bit("mask0 match", mt_m, 1);
    cmp_bit("model mask0 match", mmatch[0], 1);

    // Inverted load from B, then comparator catches it.
    pattern = 8'hF0; mask = 8'hFF;
    step(2'd1, .s(1), .inv(1), .b(8'h0F));
    cmp("load inv valueOut", vo_m, 8'hF0);
    cmp_bit("match before latency", mt_m, 0);
    step(2'd0);
    cmp_bit("match after load", mt_m, 1);
    cmp_bit("w1 match after load", mt_1, 1);

    // Eight shifts assemble 0xB2; done pulses once.
    step(2'd1, .a(8'h00));
    for (int i = 0; i < 8; i++) begin
      step(2'd2, .sin(bits[i]));
      cmp_bit("shift done", dn_m, i == 7);
      cmp_bit("w1 done per shift", dn_1, 1);
    end
    cmp("shift assemble", vo_m, 8'hB2);
    cmp("model assemble", mval[0], 8'hB2);
    step(2'd0);
    cmp_bit("done after pulse", dn_m, 0);

    // LSB-first serialOut and shift direction.
    step(2'd1, .a(8'h81));
    cmp_bit("lsb serialOut pre", so_l, 1);
    step(2'd2, .sin(0));
    cmp("lsb shift", vo_l, 8'h40);
    cmp("msb shift", vo_m, 8'h02);

    // HOLD pauses the count.
    step(2'd1, .a(8'h3C));
    for (int i = 0; i < 5; i++) step(2'd2, .sin(1));
    step(2'd0); step(2'd0);
    cmp_bit("hold no done", dn_m, 0);
    for (int i = 0; i < 3; i++) step(2'd2, .sin(0));
    cmp_bit("done after hold", dn_m, 1);

    // LOAD restarts the count.
    step(2'd1, .a(8'h11));
    for (int i = 0; i < 5; i++) step(2'd2, .sin(1));
    step(2'd1, .a(8'h22));
    for (int i = 0; i < 3; i++) step(2'd2, .sin(1));
    cmp_bit("load restart no done", dn_m, 0);
    for (int i = 0; i < 4; i++) step(2'd2, .sin(0));
    cmp_bit("no done at 7", dn_m, 0);
    step(2'd2, .sin(1));
    cmp_bit("done after restart", dn_m, 1);

    // clkEn=0 freezes register and count.
    step(2'd3);
    for (int i = 0; i < 7; i++) step(2'd2, .sin(1));
    step(2'd2, .sin(0), .en(0));
    cmp("ce0 value", vo_m, 8'hFF);
    cmp_bit("ce0 done", dn_m, 0);
    step(2'd2, .sin(0));
    cmp_bit("done after ce0", dn_m, 1);

    // Reset wins over LOAD; reset mid-count suppresses done.
    for (int i = 0; i < 3; i++) step(2'd2, .sin(1));
    step(2'd1, .a(8'h55), .rst(1));
    cmp("reset over load", vo_m, 8'hA5);
    cmp("reset over load lsb", vo_l, 8'h3C);
    for (int i = 0; i < 7; i++) step(2'd2, .sin(0));
    cmp_bit("no done after reset", dn_m, 0);
    step(2'd2, .sin(1));
    cmp_bit("done 8 after reset", dn_m, 1);

    // Masked compare with partial mask.
    pattern = 8'h0F; mask = 8'h0F;
    step(2'd1, .a(8'hAF));
    step(2'd0);
    cmp_bit("partial mask match", mt_m, 1);
    pattern = 8'h0E;
    step(2'd0);
    cmp_bit("partial mask miss", mt_m, 0);

    step(2'd0);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
